// File: rtl/rv_pkg.sv
// rv_pkg: constants and types shared by the fetch unit and the Eka decoder.
//   XLEN                 - architectural register/address width
//   DEFAULT_RESET_VECTOR - default PC after reset
//   INST_NOP             - canonical NOP (addi x0, x0, 0) shown when no op is valid
//   opcode_e             - base opcode encodings (bits [6:0] of an instruction)
//   fetch_entry_t        - one buffered instruction together with its PC
package rv_pkg;

    localparam int unsigned     XLEN                 = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP             = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b000_0011,
        OP_IMM    = 7'b001_0011,
        OP_AUIPC  = 7'b001_0111,
        OP_STORE  = 7'b010_0011,
        OP_REG    = 7'b011_0011,
        OP_LUI    = 7'b011_0111,
        OP_BRANCH = 7'b110_0011,
        OP_JALR   = 7'b110_0111,
        OP_JAL    = 7'b110_1111,
        OP_SYSTEM = 7'b111_0011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, registered output (no bypass).
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO; a push in the same cycle is discarded
//   push        - write push_data (accepted when not full, or full with a pop)
//   pop         - consume head entry (ignored when empty)
//   head_data   - current head entry (undefined content when empty)
//   full, empty - occupancy flags
//   count       - number of valid entries
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches over a req/gnt + rvalid bus, buffers
// instructions and hands them to the decoder with a valid/ready handshake.
//   clk, rst_n               - clock, asynchronous active-low reset
//   imem_req/addr            - fetch request and word-aligned address (= pc)
//   imem_gnt                 - request accepted this cycle
//   imem_rvalid/rdata        - in-order read response
//   redirect_en/pc           - restart fetch at redirect_pc (low 2 bits ignored)
//   op_valid/inst/pc         - buffered instruction offered to the decoder
//   op_ready                 - decoder consumes the head entry
module instruction_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned     FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            op_valid,
    output logic [XLEN-1:0] op_inst,
    output logic [XLEN-1:0] op_pc,
    input  logic            op_ready
);

    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   in_flight_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            resp;
    logic            drop;
    logic            push;
    logic            pop;
    logic            tag_full;
    logic            tag_empty;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] resp_pc;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Credit uses registered occupancy only: a pop this cycle does not free a
    // slot until next cycle, so there is no combinational op_ready->imem_req path.
    assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
    assign imem_req    = rst_n && !tag_full && !fifo_full && (credit_used < CREDIT_MAX);
    assign imem_addr   = pc;

    assign grant = imem_req && imem_gnt;
    // A response with nothing outstanding (stray beat after reset) is ignored.
    assign resp  = imem_rvalid && !tag_empty;
    assign drop  = resp && (discard != '0);
    assign push  = resp && !drop && !redirect_en;
    assign pop   = op_valid && op_ready;

    assign in_flight_next = in_flight + CW'(grant) - CW'(resp);

    assign push_entry = '{pc: resp_pc, inst: imem_rdata};

    // Request PCs in issue order; its occupancy is the in-flight count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (resp),
        .head_data (resp_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (in_flight)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign op_valid = !fifo_empty;
    assign op_inst  = fifo_empty ? INST_NOP     : head_entry.inst;
    assign op_pc    = fifo_empty ? RESET_VECTOR : head_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            discard <= '0;
        end else begin
            if (redirect_en)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (grant)   pc <= pc + XLEN'(4);

            // Every response still outstanding after this cycle belongs to
            // the old path, including one granted in the redirect cycle.
            if (redirect_en)  discard <= in_flight_next;
            else if (drop)    discard <= discard - CW'(1);
        end
    end

endmodule
